// File: rtl/cache_pkg.sv
// Shared types and constants for the cache miss-fill logic.
package cache_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    TAG  = 2'd2
  } fill_state_t;

  localparam int BLOCK_OFFSET_W = 4;
  localparam int WORD_OFF_W     = 3;
  localparam int WORD_BYTES     = 2;

endpackage

// File: rtl/cache_fill_fsm_if.sv
// Miss/memory/array-write bundle between the fill FSM and its surroundings.
// master: the fill FSM. slave: cache pipeline, main memory and arrays.
interface cache_fill_fsm_if
  import cache_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
) ();

  logic                  miss_detected;
  logic [ADDR_W-1:0]     miss_address;
  logic [DATA_W-1:0]     memory_data;
  logic                  memory_data_valid;
  logic                  mem_req;
  logic [ADDR_W-1:0]     memory_address;
  logic                  fsm_busy;
  logic                  write_data_array;
  logic [WORD_OFF_W-1:0] fill_word;
  logic                  write_tag_array;
  logic [ADDR_W-1:0]     fill_address;

  modport master (
    input  miss_detected, miss_address, memory_data, memory_data_valid,
    output mem_req, memory_address, fsm_busy, write_data_array,
           fill_word, write_tag_array, fill_address
  );

  modport slave (
    output miss_detected, miss_address, memory_data, memory_data_valid,
    input  mem_req, memory_address, fsm_busy, write_data_array,
           fill_word, write_tag_array, fill_address
  );

endinterface

// File: rtl/cache_fill_counter.sv
// Up-counter with synchronous clear and enable that holds at TERMINAL.
// at_term flags when the count equals TERMINAL.
module cache_fill_counter #(
  parameter int CNT_W    = 4,
  parameter int TERMINAL = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] cnt,
  output logic             at_term
);

  assign at_term = (cnt == CNT_W'(TERMINAL));

  // Count up on enable, stop at the terminal value, clear on request.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && !at_term) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/cache_fill_fsm.sv
// Cache miss fill engine: fetches one aligned block word by word from a
// pipelined memory, streams the returned words into the data array, then
// pulses a single tag/metadata write. fsm_busy stalls the pipeline meanwhile.
// Optional build macro CACHE_FILL_PERF_EN adds saturating miss_count and
// fill_cycles performance counters.
module cache_fill_fsm
  import cache_pkg::*;
#(
  parameter int ADDR_W          = 16,
  parameter int DATA_W          = 16,
  parameter int WORDS_PER_BLOCK = 8
) (
  input  logic              clk,
  input  logic              rst,
  cache_fill_fsm_if.master  bus
`ifdef CACHE_FILL_PERF_EN
  ,
  output logic [15:0]       miss_count,
  output logic [15:0]       fill_cycles
`endif
);

  localparam int REQ_W = $clog2(WORDS_PER_BLOCK + 1);
  localparam int BYTE_SHIFT = $clog2(WORD_BYTES);

  fill_state_t           state;
  fill_state_t           state_nxt;
  logic                  accept;
  logic [ADDR_W-1:0]     fill_base;
  logic [REQ_W-1:0]      req_cnt;
  logic                  req_done;
  logic [WORD_OFF_W-1:0] ret_cnt;
  logic                  ret_last;
  logic                  in_fill;

  // The data array takes memory_data straight from the bus, and the low
  // miss_address bits are the in-block offset, so neither feeds logic here.
  logic unused_inputs;
  assign unused_inputs = ^{bus.memory_data[DATA_W-1:0],
                           bus.miss_address[BLOCK_OFFSET_W-1:0]};

  assign accept  = (state == IDLE) && bus.miss_detected;
  assign in_fill = (state == FILL);

  cache_fill_counter #(
    .CNT_W    (REQ_W),
    .TERMINAL (WORDS_PER_BLOCK)
  ) u_req_cnt (
    .clk     (clk),
    .rst     (rst),
    .clr     (accept),
    .en      (in_fill),
    .cnt     (req_cnt),
    .at_term (req_done)
  );

  cache_fill_counter #(
    .CNT_W    (WORD_OFF_W),
    .TERMINAL (WORDS_PER_BLOCK - 1)
  ) u_ret_cnt (
    .clk     (clk),
    .rst     (rst),
    .clr     (accept),
    .en      (in_fill && bus.memory_data_valid),
    .cnt     (ret_cnt),
    .at_term (ret_last)
  );

  // State register; an asynchronous reset aborts any fill in progress.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Block base address captured when a miss is accepted.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fill_base <= '0;
    end else if (accept) begin
      fill_base <= {bus.miss_address[ADDR_W-1:BLOCK_OFFSET_W], BLOCK_OFFSET_W'(0)};
    end
  end

  // Next-state: leave FILL on the last returned word, TAG lasts one cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.miss_detected) state_nxt = FILL;
      FILL:    if (bus.memory_data_valid && ret_last) state_nxt = TAG;
      TAG:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs: requests and array writes run concurrently during FILL.
  always_comb begin
    bus.mem_req          = 1'b0;
    bus.memory_address   = '0;
    bus.fsm_busy         = 1'b0;
    bus.write_data_array = 1'b0;
    bus.write_tag_array  = 1'b0;
    case (state)
      FILL: begin
        bus.fsm_busy         = 1'b1;
        bus.write_data_array = bus.memory_data_valid;
        if (!req_done) begin
          bus.mem_req        = 1'b1;
          bus.memory_address = fill_base + (ADDR_W'(req_cnt) << BYTE_SHIFT);
        end
      end
      TAG: begin
        bus.fsm_busy        = 1'b1;
        bus.write_tag_array = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.fill_word    = ret_cnt;
  assign bus.fill_address = fill_base;

`ifdef CACHE_FILL_PERF_EN
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Saturating counts of accepted misses and stalled (busy) cycles.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      miss_count  <= '0;
      fill_cycles <= '0;
    end else begin
      if (accept)       miss_count  <= sat_inc(miss_count);
      if (bus.fsm_busy) fill_cycles <= sat_inc(fill_cycles);
    end
  end
`endif

endmodule

// File: tb/tb_cache_fill_fsm.sv
// Directed bench for cache_fill_fsm: per-cycle vector tables for whole fills
// with a fixed 4-cycle memory, plus hand sequences for reset and abort.
module tb_cache_fill_fsm;

  logic clk = 1'b0;
  logic rst = 1'b0;

  always #5 clk = ~clk;

  cache_fill_fsm_if #(.ADDR_W(16), .DATA_W(16)) bus ();

`ifdef CACHE_FILL_PERF_EN
  logic [15:0] miss_count;
  logic [15:0] fill_cycles;
`endif

  cache_fill_fsm #(
    .ADDR_W          (16),
    .DATA_W          (16),
    .WORDS_PER_BLOCK (8)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef CACHE_FILL_PERF_EN
    ,
    .miss_count  (miss_count),
    .fill_cycles (fill_cycles)
`endif
  );

  typedef struct {
    logic        miss;
    logic [15:0] maddr;
    logic        dv;
    logic [15:0] mdata;
    logic        e_req;
    logic [15:0] e_addr;
    logic        e_busy;
    logic        e_wr;
    logic [2:0]  e_word;
    logic        e_tag;
    logic [15:0] e_faddr;
  } vec_t;

  vec_t tbl [15];

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input int idx,
                     input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d] got 0x%0h want 0x%0h", name, idx, act, exp);
    end
  endtask

  // Cycle c of a fill (c=0 is the cycle the miss is presented).
  task automatic build(input logic [15:0] miss_addr, input logic [15:0] prev_base,
                       input int stray_cyc, input logic [15:0] stray_addr,
                       input logic next_miss, input logic [15:0] next_addr);
    logic [15:0] base;
    base = {miss_addr[15:4], 4'h0};
    for (int c = 0; c < 15; c++) begin
      tbl[c].miss  = (c == 0) || (c == stray_cyc) || (c == 14 && next_miss);
      tbl[c].maddr = (c == 0) ? miss_addr :
                     (c == stray_cyc) ? stray_addr :
                     (c == 14 && next_miss) ? next_addr : 16'h0000;
      tbl[c].dv      = (c >= 5) && (c <= 12);
      tbl[c].mdata   = tbl[c].dv ? 16'hA000 + 16'(c - 5) : 16'h5A5A;
      tbl[c].e_req   = (c >= 1) && (c <= 8);
      tbl[c].e_addr  = tbl[c].e_req ? base + 16'(2 * (c - 1)) : 16'h0000;
      tbl[c].e_busy  = (c >= 1) && (c <= 13);
      tbl[c].e_wr    = tbl[c].dv;
      tbl[c].e_word  = 3'(c - 5);
      tbl[c].e_tag   = (c == 13);
      tbl[c].e_faddr = (c == 0) ? prev_base : base;
    end
  endtask

  task automatic run_rows(input int first, input int last, input string tag);
    for (int i = first; i <= last; i++) begin
      @(posedge clk);
      #1;
      bus.miss_detected     = tbl[i].miss;
      bus.miss_address      = tbl[i].maddr;
      bus.memory_data_valid = tbl[i].dv;
      bus.memory_data       = tbl[i].mdata;
      @(negedge clk);
      chk({tag, "_req"},   i, 32'(bus.mem_req),          32'(tbl[i].e_req));
      chk({tag, "_addr"},  i, 32'(bus.memory_address),   32'(tbl[i].e_addr));
      chk({tag, "_busy"},  i, 32'(bus.fsm_busy),         32'(tbl[i].e_busy));
      chk({tag, "_wr"},    i, 32'(bus.write_data_array), 32'(tbl[i].e_wr));
      chk({tag, "_tag"},   i, 32'(bus.write_tag_array),  32'(tbl[i].e_tag));
      chk({tag, "_faddr"}, i, 32'(bus.fill_address),     32'(tbl[i].e_faddr));
      if (tbl[i].e_wr) chk({tag, "_word"}, i, 32'(bus.fill_word), 32'(tbl[i].e_word));
    end
  endtask

  task automatic chk_idle_zero(input string tag, input int idx);
    chk({tag, "_req"},   idx, 32'(bus.mem_req),          32'd0);
    chk({tag, "_addr"},  idx, 32'(bus.memory_address),   32'd0);
    chk({tag, "_busy"},  idx, 32'(bus.fsm_busy),         32'd0);
    chk({tag, "_wr"},    idx, 32'(bus.write_data_array), 32'd0);
    chk({tag, "_tag"},   idx, 32'(bus.write_tag_array),  32'd0);
    chk({tag, "_word"},  idx, 32'(bus.fill_word),        32'd0);
    chk({tag, "_faddr"}, idx, 32'(bus.fill_address),     32'd0);
  endtask

  initial begin
    bus.miss_detected     = 1'b0;
    bus.miss_address      = 16'h0000;
    bus.memory_data       = 16'h0000;
    bus.memory_data_valid = 1'b0;

    // Reset held 3 cycles; valid pulses must not produce writes.
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      bus.memory_data_valid = 1'b1;
      bus.memory_data       = 16'hBEEF;
      @(negedge clk);
      chk_idle_zero("rst", i);
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    chk("idle_dv_wr",   0, 32'(bus.write_data_array), 32'd0);
    chk("idle_dv_busy", 0, 32'(bus.fsm_busy),         32'd0);

    // Fill on 0x1236 with a stray miss on 0x4440 in the middle.
    build(16'h1236, 16'h0000, 6, 16'h4440, 1'b0, 16'h0000);
    run_rows(0, 14, "fillA");

    // Top block 0xFFFE, then back-to-back miss on 0x0000 in the IDLE cycle.
    build(16'hFFFE, 16'h1230, -1, 16'h0000, 1'b1, 16'h0000);
    run_rows(0, 14, "fillB");
`ifdef CACHE_FILL_PERF_EN
    chk("miss_count",  0, 32'(miss_count),  32'd2);
    chk("fill_cycles", 0, 32'(fill_cycles), 32'd26);
`endif
    build(16'h0000, 16'hFFF0, -1, 16'h0000, 1'b0, 16'h0000);
    run_rows(1, 14, "fillC");

    // Abort after the third data write.
    build(16'h2000, 16'h0000, -1, 16'h0000, 1'b0, 16'h0000);
    run_rows(0, 7, "abort");
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.miss_detected     = 1'b0;
    bus.memory_data_valid = 1'b1;
    bus.memory_data       = 16'hA003;
    #1;
    chk_idle_zero("abort_rst", 0);
    for (int i = 1; i < 3; i++) begin
      @(negedge clk);
      chk("abort_tag",  i, 32'(bus.write_tag_array),  32'd0);
      chk("abort_wr",   i, 32'(bus.write_data_array), 32'd0);
      chk("abort_busy", i, 32'(bus.fsm_busy),         32'd0);
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
    bus.memory_data_valid = 1'b0;

    // Next miss restarts at fill_word 0.
    build(16'h3008, 16'h0000, -1, 16'h0000, 1'b0, 16'h0000);
    run_rows(0, 14, "restart");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
